// File: rtl/device_info_regs_pkg.sv
// Shared word offsets, control bit positions and address decode for the
// device identification / housekeeping register block.
package device_info_regs_pkg;

    localparam int DEVINFO_ID           = 0;
    localparam int DEVINFO_REV          = 1;
    localparam int DEVINFO_UPT_LO       = 2;
    localparam int DEVINFO_UPT_HI       = 3;
    localparam int DEVINFO_CTRL         = 4;
    localparam int DEVINFO_ERR          = 5;
    localparam int DEVINFO_SCRATCH_BASE = 8;

    localparam int CTRL_LOCK_BIT    = 0;
    localparam int CTRL_UPT_CLR_BIT = 1;

    localparam logic [31:0] DEVINFO_BAD_ADDR = 32'hDEAD_BEEF;
    localparam int          ERR_COUNT_WIDTH  = 16;

    typedef enum logic [3:0] {
        RGN_ID,
        RGN_REV,
        RGN_UPT_LO,
        RGN_UPT_HI,
        RGN_CTRL,
        RGN_ERR,
        RGN_SCRATCH,
        RGN_STR,
        RGN_INVALID
    } region_e;

    // Map a word address onto the register region it selects. Reserved
    // words 6-7 and anything past the string fall into RGN_INVALID.
    function automatic region_e decode_region(input int addr,
                                              input int numScratch,
                                              input int strWords);
        region_e rgn;
        if (addr == DEVINFO_ID)
            rgn = RGN_ID;
        else if (addr == DEVINFO_REV)
            rgn = RGN_REV;
        else if (addr == DEVINFO_UPT_LO)
            rgn = RGN_UPT_LO;
        else if (addr == DEVINFO_UPT_HI)
            rgn = RGN_UPT_HI;
        else if (addr == DEVINFO_CTRL)
            rgn = RGN_CTRL;
        else if (addr == DEVINFO_ERR)
            rgn = RGN_ERR;
        else if (addr >= DEVINFO_SCRATCH_BASE &&
                 addr <  DEVINFO_SCRATCH_BASE + numScratch)
            rgn = RGN_SCRATCH;
        else if (addr >= DEVINFO_SCRATCH_BASE + numScratch &&
                 addr <  DEVINFO_SCRATCH_BASE + numScratch + strWords)
            rgn = RGN_STR;
        else
            rgn = RGN_INVALID;
        return rgn;
    endfunction

endpackage

// File: rtl/device_info_regs_uptime_ctr.sv
// Free-running 2*WIDTH uptime counter with a synchronous clear and a
// snapshot strobe that captures the high word so split reads stay coherent.
module devinfo_uptime_ctr #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             snap_i,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_shadow_o
);

    logic [2*WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   hiShadow_q, hiShadow_d;

    // Clear beats increment; the shadow grabs the high half of the value
    // being returned as the low word on the same edge.
    always_comb begin
        cnt_d      = cnt_q + {{(2*WIDTH-1){1'b0}}, 1'b1};
        hiShadow_d = hiShadow_q;
        if (clr_i)
            cnt_d = '0;
        if (snap_i)
            hiShadow_d = cnt_q[2*WIDTH-1:WIDTH];
    end

    // Counter and shadow registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q      <= '0;
            hiShadow_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            hiShadow_q <= hiShadow_d;
        end
    end

    assign lo_o        = cnt_q[WIDTH-1:0];
    assign hi_shadow_o = hiShadow_q;

endmodule

// File: rtl/device_info_regs.sv
// Device identification and housekeeping register slave: ID/revision,
// uptime with coherent split reads, lockable control, scratch words,
// a constant device string and a saturating invalid-access counter.
module device_info_regs
    import device_info_regs_pkg::*;
#(
    parameter int                              DATA_WIDTH  = 32,
    parameter int                              ADDR_WIDTH  = 6,
    parameter logic [DATA_WIDTH-1:0]           DEVICE_ID   = '0,
    parameter logic [DATA_WIDTH-1:0]           REVISION    = '0,
    parameter int                              NUM_SCRATCH = 4,
    parameter int                              STR_WORDS   = 16,
    parameter logic [STR_WORDS*DATA_WIDTH-1:0] DEVICE_STR  = "Undefined device"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_req,
    input  logic                  reg_rd_wr_L,
    input  logic [ADDR_WIDTH-1:0] reg_addr,
    input  logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic                  reg_ack,
    output logic [DATA_WIDTH-1:0] reg_rd_data
);

    localparam int STR_BASE  = DEVINFO_SCRATCH_BASE + NUM_SCRATCH;
    localparam int STR_BITS  = STR_WORDS * DATA_WIDTH;
    localparam int STR_BYTES = STR_BITS / 8;

    localparam logic [DATA_WIDTH-1:0] BAD_WORD = DATA_WIDTH'(DEVINFO_BAD_ADDR);

    // A string literal lands right-aligned in the parameter vector; strip the
    // leading NUL bytes so the first character sits in the top byte of word 0.
    function automatic logic [STR_BITS-1:0] align_str(input logic [STR_BITS-1:0] s);
        int   lead;
        logic stillZero;
        lead      = 0;
        stillZero = 1'b1;
        for (int i = STR_BYTES - 1; i >= 0; i--) begin
            if (stillZero && s[8*i +: 8] == 8'h00)
                lead++;
            else
                stillZero = 1'b0;
        end
        return s << (8 * lead);
    endfunction

    localparam logic [STR_BITS-1:0] STR_ALIGNED = align_str(DEVICE_STR);

    logic                       reqAcked_q, reqAcked_d;
    logic                       regAck_q, regAck_d;
    logic [DATA_WIDTH-1:0]      rdData_q, rdData_d;
    logic                       lock_q, lock_d;
    logic [ERR_COUNT_WIDTH-1:0] errCnt_q, errCnt_d;
    logic [DATA_WIDTH-1:0]      scratch_q [NUM_SCRATCH];
    logic [DATA_WIDTH-1:0]      scratch_d [NUM_SCRATCH];

    int                    addrInt;
    region_e               region;
    logic                  accept, isRead, isWrite;
    logic [DATA_WIDTH-1:0] readWord;
    logic                  errInc, errClr, uptClr, uptSnap, scratchWe, lockSet;
    logic [DATA_WIDTH-1:0] uptLo, uptHi;

    devinfo_uptime_ctr #(
        .WIDTH(DATA_WIDTH)
    ) u_uptime (
        .clk_i       (clk),
        .reset_i     (reset),
        .clr_i       (uptClr),
        .snap_i      (uptSnap),
        .lo_o        (uptLo),
        .hi_shadow_o (uptHi)
    );

    // Handshake qualification and address decode: a request is taken only
    // on the first edge it is seen high after having been low.
    always_comb begin
        addrInt = int'(32'(reg_addr));
        region  = decode_region(addrInt, NUM_SCRATCH, STR_WORDS);
        accept  = reg_req & ~reqAcked_q;
        isRead  = accept & reg_rd_wr_L;
        isWrite = accept & ~reg_rd_wr_L;
        uptSnap = isRead && (region == RGN_UPT_LO);
    end

    // Read data selection for the addressed word.
    always_comb begin
        readWord = '0;
        case (region)
            RGN_ID:     readWord = DEVICE_ID;
            RGN_REV:    readWord = REVISION;
            RGN_UPT_LO: readWord = uptLo;
            RGN_UPT_HI: readWord = uptHi;
            RGN_CTRL:   readWord[CTRL_LOCK_BIT] = lock_q;
            RGN_ERR:    readWord[ERR_COUNT_WIDTH-1:0] = errCnt_q;
            RGN_SCRATCH: begin
                for (int i = 0; i < NUM_SCRATCH; i++)
                    if (addrInt == DEVINFO_SCRATCH_BASE + i)
                        readWord = scratch_q[i];
            end
            RGN_STR: begin
                for (int k = 0; k < STR_WORDS; k++)
                    if (addrInt == STR_BASE + k)
                        readWord = STR_ALIGNED[(STR_WORDS-k)*DATA_WIDTH-1 -: DATA_WIDTH];
            end
            default:    readWord = BAD_WORD;
        endcase
    end

    // Decide what an accepted access does: commit, clear, or count as an
    // error (bad address, write to a read-only word, or blocked by LOCK).
    always_comb begin
        errInc    = 1'b0;
        errClr    = 1'b0;
        uptClr    = 1'b0;
        scratchWe = 1'b0;
        lockSet   = 1'b0;
        if (isRead && region == RGN_INVALID)
            errInc = 1'b1;
        if (isWrite) begin
            case (region)
                RGN_CTRL: begin
                    lockSet = reg_wr_data[CTRL_LOCK_BIT];
                    if (reg_wr_data[CTRL_UPT_CLR_BIT]) begin
                        if (lock_q)
                            errInc = 1'b1;
                        else
                            uptClr = 1'b1;
                    end
                end
                RGN_ERR: begin
                    if (lock_q)
                        errInc = 1'b1;
                    else
                        errClr = 1'b1;
                end
                RGN_SCRATCH: begin
                    if (lock_q)
                        errInc = 1'b1;
                    else
                        scratchWe = 1'b1;
                end
                default: errInc = 1'b1;
            endcase
        end
    end

    // Next-state for the handshake, read data, lock, error counter and
    // scratch words; the acked flag simply follows reg_req.
    always_comb begin
        reqAcked_d = reg_req;
        regAck_d   = accept;
        rdData_d   = isRead ? readWord : rdData_q;
        lock_d     = lock_q | lockSet;
        errCnt_d   = errCnt_q;
        if (errClr)
            errCnt_d = '0;
        else if (errInc && errCnt_q != {ERR_COUNT_WIDTH{1'b1}})
            errCnt_d = errCnt_q + {{(ERR_COUNT_WIDTH-1){1'b0}}, 1'b1};
        for (int i = 0; i < NUM_SCRATCH; i++)
            scratch_d[i] = (scratchWe && addrInt == DEVINFO_SCRATCH_BASE + i) ?
                           reg_wr_data : scratch_q[i];
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            reqAcked_q <= 1'b0;
            regAck_q   <= 1'b0;
            rdData_q   <= '0;
            lock_q     <= 1'b0;
            errCnt_q   <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++)
                scratch_q[i] <= '0;
        end else begin
            reqAcked_q <= reqAcked_d;
            regAck_q   <= regAck_d;
            rdData_q   <= rdData_d;
            lock_q     <= lock_d;
            errCnt_q   <= errCnt_d;
            for (int i = 0; i < NUM_SCRATCH; i++)
                scratch_q[i] <= scratch_d[i];
        end
    end

    assign reg_ack     = regAck_q;
    assign reg_rd_data = rdData_q;

endmodule

// File: tb/tb_device_info_regs.sv
// Directed self-checking bench for device_info_regs with a 32-bit word,
// four scratch words and the string "NetFPGA".
module tb_device_info_regs;

    logic        clk;
    logic        reset;
    logic        reg_req;
    logic        reg_rd_wr_L;
    logic [5:0]  reg_addr;
    logic [31:0] reg_wr_data;
    logic        reg_ack;
    logic [31:0] reg_rd_data;

    int assertCount = 0;
    int failCount   = 0;

    device_info_regs #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (6),
        .DEVICE_ID   (32'h0000_0042),
        .REVISION    (32'h0000_0107),
        .NUM_SCRATCH (4),
        .STR_WORDS   (16),
        .DEVICE_STR  ("NetFPGA")
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .reg_req     (reg_req),
        .reg_rd_wr_L (reg_rd_wr_L),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_ack     (reg_ack),
        .reg_rd_data (reg_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One complete bus transaction; returns the read data seen with the ack
    // and the ack latency in cycles.
    task automatic bus_access(input logic rd, input logic [5:0] addr,
                              input logic [31:0] wdata,
                              output logic [31:0] rdata, output int lat);
        logic got;
        @(negedge clk);
        reg_req     = 1'b1;
        reg_rd_wr_L = rd;
        reg_addr    = addr;
        reg_wr_data = wdata;
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (reg_ack === 1'b1) begin
                got = 1'b1;
                lat = c;
                break;
            end
        end
        rdata   = reg_rd_data;
        reg_req = 1'b0;
        assertCount++;
        if (!got) begin
            failCount++;
            $display("[TB] FAIL ack_timeout addr=%0d: observed no ack, expected ack within 16 cycles", addr);
        end
    endtask

    task automatic rd_reg(input logic [5:0] addr, output logic [31:0] data);
        int lat;
        bus_access(1'b1, addr, 32'h0, data, lat);
    endtask

    task automatic wr_reg(input logic [5:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        int lat;
        bus_access(1'b0, addr, data, dummy, lat);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        assertCount++;
        if (reg_ack !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_ack: observed %b, expected 0", reg_ack);
        end
        assertCount++;
        if (reg_rd_data !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL reset_rd_data: observed %h, expected 00000000", reg_rd_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_id();
        logic [31:0] d;
        int lat;
        int acks;
        bus_access(1'b1, 6'd0, 32'h0, d, lat);
        assertCount++;
        if (d !== 32'h0000_0042) begin
            failCount++;
            $display("[TB] FAIL id_data: observed %h, expected 00000042", d);
        end
        assertCount++;
        if (lat != 1) begin
            failCount++;
            $display("[TB] FAIL id_latency: observed %0d, expected 1", lat);
        end
        @(negedge clk);
        reg_req     = 1'b1;
        reg_rd_wr_L = 1'b1;
        reg_addr    = 6'd1;
        acks = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (reg_ack === 1'b1) acks++;
        end
        reg_req = 1'b0;
        assertCount++;
        if (acks != 1) begin
            failCount++;
            $display("[TB] FAIL hold_single_ack: observed %0d acks, expected 1", acks);
        end
        assertCount++;
        if (reg_rd_data !== 32'h0000_0107) begin
            failCount++;
            $display("[TB] FAIL rev_data: observed %h, expected 00000107", reg_rd_data);
        end
    endtask

    task automatic test_string();
        logic [31:0] d;
        rd_reg(6'd12, d);
        assertCount++;
        if (d !== 32'h4E65_7446) begin
            failCount++;
            $display("[TB] FAIL str_word0: observed %h, expected 4e657446", d);
        end
        rd_reg(6'd13, d);
        assertCount++;
        if (d !== 32'h5047_4100) begin
            failCount++;
            $display("[TB] FAIL str_word1: observed %h, expected 50474100", d);
        end
        rd_reg(6'd14, d);
        assertCount++;
        if (d !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL str_word2: observed %h, expected 00000000", d);
        end
        rd_reg(6'd27, d);
        assertCount++;
        if (d !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL str_last_word: observed %h, expected 00000000", d);
        end
        rd_reg(6'd5, d);
        assertCount++;
        if (d !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL str_no_err: observed %h, expected 00000000", d);
        end
    endtask

    task automatic test_invalid();
        logic [31:0] d;
        rd_reg(6'd6, d);
        assertCount++;
        if (d !== 32'hDEAD_BEEF) begin
            failCount++;
            $display("[TB] FAIL bad_addr6: observed %h, expected deadbeef", d);
        end
        rd_reg(6'd63, d);
        assertCount++;
        if (d !== 32'hDEAD_BEEF) begin
            failCount++;
            $display("[TB] FAIL bad_addr63: observed %h, expected deadbeef", d);
        end
        rd_reg(6'd5, d);
        assertCount++;
        if (d !== 32'h2) begin
            failCount++;
            $display("[TB] FAIL err_after_two: observed %h, expected 00000002", d);
        end
        wr_reg(6'd0, 32'hFFFF_FFFF);
        rd_reg(6'd5, d);
        assertCount++;
        if (d !== 32'h3) begin
            failCount++;
            $display("[TB] FAIL err_ro_write: observed %h, expected 00000003", d);
        end
        rd_reg(6'd0, d);
        assertCount++;
        if (d !== 32'h0000_0042) begin
            failCount++;
            $display("[TB] FAIL id_after_ro_write: observed %h, expected 00000042", d);
        end
        wr_reg(6'd5, 32'h1234);
        rd_reg(6'd5, d);
        assertCount++;
        if (d !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL err_clear: observed %h, expected 00000000", d);
        end
    endtask

    task automatic test_err_saturate();
        logic [31:0] d;
        @(negedge clk);
        force dut.errCnt_q = 16'hFFFE;
        #1;
        release dut.errCnt_q;
        rd_reg(6'd7, d);
        rd_reg(6'd5, d);
        assertCount++;
        if (d !== 32'h0000_FFFF) begin
            failCount++;
            $display("[TB] FAIL err_reach_max: observed %h, expected 0000ffff", d);
        end
        rd_reg(6'd63, d);
        rd_reg(6'd5, d);
        assertCount++;
        if (d !== 32'h0000_FFFF) begin
            failCount++;
            $display("[TB] FAIL err_saturate: observed %h, expected 0000ffff", d);
        end
        wr_reg(6'd5, 32'h0);
        rd_reg(6'd5, d);
        assertCount++;
        if (d !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL err_clear_from_max: observed %h, expected 00000000", d);
        end
    endtask

    task automatic test_uptime();
        logic [31:0] d;
        @(negedge clk);
        force dut.u_uptime.cnt_q = 64'h0000_0000_FFFF_FFFE;
        #1;
        release dut.u_uptime.cnt_q;
        reg_req     = 1'b1;
        reg_rd_wr_L = 1'b1;
        reg_addr    = 6'd2;
        @(negedge clk);
        assertCount++;
        if (reg_ack !== 1'b1 || reg_rd_data !== 32'hFFFF_FFFE) begin
            failCount++;
            $display("[TB] FAIL upt_lo_prewrap: observed ack=%b data=%h, expected ack=1 data=fffffffe", reg_ack, reg_rd_data);
        end
        reg_req = 1'b0;
        @(negedge clk);
        reg_req  = 1'b1;
        reg_addr = 6'd3;
        @(negedge clk);
        assertCount++;
        if (reg_ack !== 1'b1 || reg_rd_data !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL upt_hi_prewrap: observed ack=%b data=%h, expected ack=1 data=00000000", reg_ack, reg_rd_data);
        end
        reg_req = 1'b0;
        @(negedge clk);
        reg_req  = 1'b1;
        reg_addr = 6'd2;
        @(negedge clk);
        assertCount++;
        if (reg_rd_data !== 32'h0000_0002) begin
            failCount++;
            $display("[TB] FAIL upt_lo_postwrap: observed %h, expected 00000002", reg_rd_data);
        end
        reg_req = 1'b0;
        @(negedge clk);
        reg_req  = 1'b1;
        reg_addr = 6'd3;
        @(negedge clk);
        assertCount++;
        if (reg_rd_data !== 32'h0000_0001) begin
            failCount++;
            $display("[TB] FAIL upt_hi_postwrap: observed %h, expected 00000001", reg_rd_data);
        end
        reg_req = 1'b0;
        wr_reg(6'd4, 32'h2);
        rd_reg(6'd2, d);
        assertCount++;
        if (d >= 32'd10) begin
            failCount++;
            $display("[TB] FAIL upt_clear_lo: observed %h, expected below 0000000a", d);
        end
        rd_reg(6'd3, d);
        assertCount++;
        if (d !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL upt_clear_hi: observed %h, expected 00000000", d);
        end
        rd_reg(6'd4, d);
        assertCount++;
        if (d !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL ctrl_selfclear: observed %h, expected 00000000", d);
        end
    endtask

    task automatic test_lock();
        logic [31:0] d;
        wr_reg(6'd8, 32'hA5A5_A5A5);
        rd_reg(6'd8, d);
        assertCount++;
        if (d !== 32'hA5A5_A5A5) begin
            failCount++;
            $display("[TB] FAIL scratch0_rw: observed %h, expected a5a5a5a5", d);
        end
        wr_reg(6'd4, 32'h1);
        rd_reg(6'd4, d);
        assertCount++;
        if (d !== 32'h1) begin
            failCount++;
            $display("[TB] FAIL lock_set: observed %h, expected 00000001", d);
        end
        wr_reg(6'd8, 32'h0);
        rd_reg(6'd8, d);
        assertCount++;
        if (d !== 32'hA5A5_A5A5) begin
            failCount++;
            $display("[TB] FAIL scratch_locked: observed %h, expected a5a5a5a5", d);
        end
        rd_reg(6'd5, d);
        assertCount++;
        if (d !== 32'h1) begin
            failCount++;
            $display("[TB] FAIL err_locked_scratch: observed %h, expected 00000001", d);
        end
        wr_reg(6'd4, 32'h0);
        rd_reg(6'd4, d);
        assertCount++;
        if (d !== 32'h1) begin
            failCount++;
            $display("[TB] FAIL lock_sticky: observed %h, expected 00000001", d);
        end
        wr_reg(6'd5, 32'h0);
        rd_reg(6'd5, d);
        assertCount++;
        if (d !== 32'h2) begin
            failCount++;
            $display("[TB] FAIL err_locked_errwrite: observed %h, expected 00000002", d);
        end
        wr_reg(6'd4, 32'h2);
        rd_reg(6'd5, d);
        assertCount++;
        if (d !== 32'h3) begin
            failCount++;
            $display("[TB] FAIL err_locked_uptclr: observed %h, expected 00000003", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int acks;
        @(negedge clk);
        reg_req     = 1'b1;
        reg_rd_wr_L = 1'b1;
        reg_addr    = 6'd1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        assertCount++;
        if (reg_ack !== 1'b0 || reg_rd_data !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL midreset_outputs: observed ack=%b data=%h, expected ack=0 data=00000000", reg_ack, reg_rd_data);
        end
        reset = 1'b0;
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (reg_ack === 1'b1) acks++;
        end
        reg_req = 1'b0;
        assertCount++;
        if (acks != 1) begin
            failCount++;
            $display("[TB] FAIL midreset_reack: observed %0d acks, expected 1", acks);
        end
        assertCount++;
        if (reg_rd_data !== 32'h0000_0107) begin
            failCount++;
            $display("[TB] FAIL midreset_data: observed %h, expected 00000107", reg_rd_data);
        end
        rd_reg(6'd4, d);
        assertCount++;
        if (d !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL lock_after_reset: observed %h, expected 00000000", d);
        end
        rd_reg(6'd8, d);
        assertCount++;
        if (d !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL scratch_after_reset: observed %h, expected 00000000", d);
        end
        rd_reg(6'd5, d);
        assertCount++;
        if (d !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL err_after_reset: observed %h, expected 00000000", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int lat;
        rd_reg(6'd0, d);
        bus_access(1'b0, 6'd9, 32'h1234_5678, d, lat);
        assertCount++;
        if (d !== 32'h0000_0042) begin
            failCount++;
            $display("[TB] FAIL rd_data_hold_on_write: observed %h, expected 00000042", d);
        end
        rd_reg(6'd9, d);
        assertCount++;
        if (d !== 32'h1234_5678) begin
            failCount++;
            $display("[TB] FAIL scratch1_readback: observed %h, expected 12345678", d);
        end
        wr_reg(6'd11, 32'hCAFE_F00D);
        rd_reg(6'd11, d);
        assertCount++;
        if (d !== 32'hCAFE_F00D) begin
            failCount++;
            $display("[TB] FAIL scratch3_readback: observed %h, expected cafef00d", d);
        end
        rd_reg(6'd9, d);
        assertCount++;
        if (d !== 32'h1234_5678) begin
            failCount++;
            $display("[TB] FAIL scratch1_kept: observed %h, expected 12345678", d);
        end
    endtask

    initial begin
        reset       = 1'b1;
        reg_req     = 1'b0;
        reg_rd_wr_L = 1'b1;
        reg_addr    = 6'd0;
        reg_wr_data = 32'h0;
        $display("[TB] starting device_info_regs bench");
        test_reset();
        test_read_id();
        test_string();
        test_invalid();
        test_err_saturate();
        test_uptime();
        test_lock();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
